stage_ex_muldiv: RTL and testbench
==================================

Name: stage_ex_muldiv

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the combinational EX stage ALU.
- ID presents the operation and operands.
- The unit stalls the pipeline through stall_request while it iterates.
- The unit owns HI/LO and exposes them to EX for MFHI/MFLO forwarding.
- It adds what the combinational EX stage lacks: MULT/MULTU/DIV/DIVU, MTHI/MTLO and multi-cycle stall generation.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits.
- MUL_STEP, 1, multiplier bits retired per CALC cycle. Must divide WIDTH evenly.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- op_valid  input  1  ID presents an operation this cycle.
- op_code  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, others=no-op.
- operand_a  input  WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- operand_b  input  WIDTH  multiplier/divisor.
- flush  input  1  abort any in-flight operation.
- stall_request  output  1  hold the pipeline.
- done  output  1  one-cycle pulse when a MULT/DIV result has been written.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for a zero divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; hi=lo=0; done=div_by_zero=0; stall_request=0.
  - Reset mid-operation discards it immediately.
- States: IDLE, CALC, FIX.
- Accept: in IDLE with op_valid=1 and flush=0.
  - MTHI/MTLO: hi (or lo) <= operand_a at the edge. Stays in IDLE, no stall.
  - MULT/MULTU/DIV/DIVU: latch operands and the sign flags sa/sb (signed ops only); work on magnitudes.
    - Divisor nonzero: go to CALC, counter = WIDTH/MUL_STEP for multiply, WIDTH for divide.
    - DIV/DIVU with divisor 0: go directly to FIX with the zero flag set.
  - Unknown op_code: ignored.
- op_valid while not in IDLE is ignored. ID holds the instruction under stall.
- CALC:
  - Multiply: shift-add of MUL_STEP bits per cycle into a 2*WIDTH accumulator.
  - Divide: restoring division, 1 quotient bit per cycle.
  - Counter decrements each cycle; goes to FIX when it reaches 1.
- FIX (1 cycle), then IDLE:
  - Apply signs:
    - Product negated if sa^sb.
    - Quotient negated if sa^sb.
    - Remainder takes the sign of the dividend.
  - Write at the FIX->IDLE edge:
    - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
    - Divide: lo=quotient, hi=remainder.
    - Zero divisor: hi/lo unchanged.
  - All arithmetic is modulo 2^WIDTH. DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0, with no trap.
- done/div_by_zero: registered. High for exactly the first IDLE cycle after FIX; hi/lo already hold the new values in that cycle.
- stall_request (combinational) = (IDLE & op_valid & mul/div op & !flush) | CALC | FIX.
  - Latency with nonzero divisor, MUL_STEP=1: stall high 1+WIDTH+1 cycles (34 at WIDTH=32).
  - Zero divisor: stall high 2 cycles.
- flush:
  - In CALC or FIX: go to IDLE next edge; hi/lo unchanged; no done pulse.
  - Flush takes priority over a simultaneous accept or FIX write.
- Back-to-back: a new op may be accepted in the cycle done is high.
- hi/lo are valid combinationally to EX every cycle. EX stalls via stall_request rather than reading partial results.

Test Plan:
- Reset with reset=0 mid-CALC (MULTU in flight) -> immediately state IDLE, hi=lo=0, stall_request=0; no done pulse after release.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall_request high 34 cycles; then done=1 for 1 cycle with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with MUL_STEP=4 -> same result, stall high 10 cycles.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then DIV b=0 -> hi=0x12345678 immediately with no stall; DIV stalls 2 cycles, done=div_by_zero=1 for one cycle, hi/lo unchanged.
- MULT issued, flush on CALC cycle 10 -> IDLE next cycle, no done, hi/lo unchanged; a new MULTU 2*3 accepted next cycle -> hi=0, lo=6.

Source files
------------

// File: rtl/stage_ex_muldiv.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// MULT/DIV stall the pipeline while iterating; MTHI/MTLO write in a single cycle.
module stage_ex_muldiv #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             stall_request,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH / MUL_STEP);
   localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return (~v) + WIDTH'(1'b1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return (~v) + (2*WIDTH)'(1'b1);
   endfunction

   state_t               state_r, state_nx_s;
   logic [CW-1:0]        cnt_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]     opnd_r;
   logic                 sa_r, sb_r, div_r, zero_r;
   logic [WIDTH-1:0]     hi_r, lo_r;
   logic                 done_r, dbz_r;

   logic                 is_mul_s, is_div_s, is_signed_s;
   logic                 accept_s, start_s, b_zero_s;
   logic [WIDTH-1:0]     mag_a_s, mag_b_s;
   logic [WIDTH+MUL_STEP-1:0] mul_sum_s;
   logic [2*WIDTH-1:0]   mul_next_s;
   logic [WIDTH:0]       trial_s;
   logic [2*WIDTH-1:0]   div_next_s;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     quot_s, rem_s;

   // Operation decode
   always_comb begin
      is_mul_s    = 1'b0;
      is_div_s    = 1'b0;
      is_signed_s = 1'b0;
      case (op_code)
         OP_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
         OP_MULTU: begin is_mul_s = 1'b1; end
         OP_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
         OP_DIVU:  begin is_div_s = 1'b1; end
         default:  begin is_mul_s = 1'b0; end
      endcase
   end

   assign accept_s      = (state_r == ST_IDLE) && op_valid && !flush;
   assign start_s       = accept_s && (is_mul_s || is_div_s);
   assign b_zero_s      = (operand_b == {WIDTH{1'b0}});
   assign mag_a_s       = (is_signed_s && operand_a[WIDTH-1]) ? neg_w(operand_a) : operand_a;
   assign mag_b_s       = (is_signed_s && operand_b[WIDTH-1]) ? neg_w(operand_b) : operand_b;
   assign stall_request = start_s || (state_r != ST_IDLE);

   // Multiply step: acc = {partial product, remaining multiplier bits}
   always_comb begin
      mul_sum_s = {{MUL_STEP{1'b0}}, acc_r[2*WIDTH-1:WIDTH]};
      for (int i = 0; i < MUL_STEP; i++) begin
         if (acc_r[i]) begin
            mul_sum_s = mul_sum_s + ({{MUL_STEP{1'b0}}, opnd_r} << i);
         end else begin
            mul_sum_s = mul_sum_s;
         end
      end
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:MUL_STEP]};
   end

   // Restoring divide step: acc = {remainder, dividend/quotient}
   assign trial_s    = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
   assign div_next_s = trial_s[WIDTH] ? {acc_r[2*WIDTH-2:0], 1'b0}
                                      : {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

   assign prod_s = (sa_r ^ sb_r) ? neg_2w(acc_r) : acc_r;
   assign quot_s = (sa_r ^ sb_r) ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
   assign rem_s  = sa_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];

   // Next-state logic; flush wins over everything in CALC/FIX
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               if (is_div_s && b_zero_s) begin
                  state_nx_s = ST_FIX;
               end else begin
                  state_nx_s = ST_CALC;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_nx_s = ST_IDLE;
            end else if (cnt_r == CNT_ONE) begin
               state_nx_s = ST_FIX;
            end else begin
               state_nx_s = ST_CALC;
            end
         end
         ST_FIX:  state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Operand latch, iteration datapath, HI/LO writeback and completion pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_r  <= {CW{1'b0}};
         acc_r  <= {(2*WIDTH){1'b0}};
         opnd_r <= {WIDTH{1'b0}};
         sa_r   <= 1'b0;
         sb_r   <= 1'b0;
         div_r  <= 1'b0;
         zero_r <= 1'b0;
         hi_r   <= {WIDTH{1'b0}};
         lo_r   <= {WIDTH{1'b0}};
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  sa_r   <= is_signed_s && operand_a[WIDTH-1];
                  sb_r   <= is_signed_s && operand_b[WIDTH-1];
                  div_r  <= is_div_s;
                  zero_r <= is_div_s && b_zero_s;
                  if (is_div_s) begin
                     opnd_r <= mag_b_s;
                     acc_r  <= {{WIDTH{1'b0}}, mag_a_s};
                     cnt_r  <= DIV_CNT;
                  end else begin
                     opnd_r <= mag_a_s;
                     acc_r  <= {{WIDTH{1'b0}}, mag_b_s};
                     cnt_r  <= MUL_CNT;
                  end
               end else if (accept_s && (op_code == OP_MTHI)) begin
                  hi_r <= operand_a;
               end else if (accept_s && (op_code == OP_MTLO)) begin
                  lo_r <= operand_a;
               end
            end
            ST_CALC: begin
               if (!flush) begin
                  acc_r <= div_r ? div_next_s : mul_next_s;
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_FIX: begin
               if (!flush) begin
                  done_r <= 1'b1;
                  dbz_r  <= zero_r;
                  if (!zero_r) begin
                     if (div_r) begin
                        lo_r <= quot_s;
                        hi_r <= rem_s;
                     end else begin
                        hi_r <= prod_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_s[WIDTH-1:0];
                     end
                  end
               end
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign done        = done_r;
   assign div_by_zero = dbz_r;
   assign hi          = hi_r;
   assign lo          = lo_r;

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Scoreboard bench for stage_ex_muldiv: two instances (MUL_STEP=1 and 4) share stimulus;
// a per-instance monitor pops expected results whenever done is seen.
module tb_stage_ex_muldiv;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      logic [7:0]   stall;
   } exp_t;

   logic           clock = 1'b0;
   logic           reset;
   logic [1:0]     op_valid_v;
   logic [2:0]     op_code;
   logic [W-1:0]   operand_a, operand_b;
   logic           flush;
   logic [1:0]     stall_v, done_v, dbz_v;
   logic [W-1:0]   hi_v [2];
   logic [W-1:0]   lo_v [2];

   exp_t exp_q [2][$];
   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      stage_ex_muldiv #(.WIDTH(W), .MUL_STEP(g == 0 ? 1 : 4)) dut (
         .clock(clock), .reset(reset), .op_valid(op_valid_v[g]), .op_code(op_code),
         .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
         .stall_request(stall_v[g]), .done(done_v[g]), .div_by_zero(dbz_v[g]),
         .hi(hi_v[g]), .lo(lo_v[g]));

      int   run_cnt = 0;
      logic done_prev = 1'b0;
      exp_t e;

      // Monitor: measure stall run length and check results on each done pulse
      always @(negedge clock) begin
         if (!reset) begin
            run_cnt   = 0;
            done_prev = 1'b0;
         end else begin
            if (done_v[g]) begin
               chk($sformatf("done_single_cycle[%0d]", g), {63'd0, done_prev}, 64'd0);
               chk($sformatf("done_expected[%0d]", g), {63'd0, exp_q[g].size() != 0}, 64'd1);
               if (exp_q[g].size() != 0) begin
                  e = exp_q[g].pop_front();
                  chk($sformatf("hi[%0d]", g), {32'd0, hi_v[g]}, {32'd0, e.hi});
                  chk($sformatf("lo[%0d]", g), {32'd0, lo_v[g]}, {32'd0, e.lo});
                  chk($sformatf("div_by_zero[%0d]", g), {63'd0, dbz_v[g]}, {63'd0, e.dbz});
                  chk($sformatf("stall_len[%0d]", g), 64'(run_cnt), {56'd0, e.stall});
               end
               run_cnt = stall_v[g] ? 1 : 0;
            end else if (stall_v[g]) begin
               run_cnt++;
            end else begin
               run_cnt = 0;
            end
            if (flush) run_cnt = 0;
            done_prev = done_v[g];
         end
      end
   end

   task automatic do_op(input logic [1:0] en, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz, input int st0, input int st1);
      exp_t e;
      int   n;
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      e.stall = 8'(st0);
      if (en[0]) exp_q[0].push_back(e);
      e.stall = 8'(st1);
      if (en[1]) exp_q[1].push_back(e);
      op_valid_v = en; op_code = op; operand_a = a; operand_b = b;
      @(posedge clock); #1;
      op_valid_v = 2'b00;
      n = 0;
      while (((stall_v & en) != 2'b00) && (n < 200)) begin
         @(posedge clock); #1;
         n++;
      end
      chk("op_completes_in_budget", {63'd0, n < 200}, 64'd1);
   endtask

   task automatic mt_op(input logic [2:0] op, input logic [W-1:0] a);
      op_valid_v = 2'b11; op_code = op; operand_a = a; operand_b = 32'h0000_0000;
      #1;
      chk("mt_no_stall", {62'd0, stall_v}, 64'd0);
      @(posedge clock); #1;
      op_valid_v = 2'b00;
      for (int i = 0; i < 2; i++) begin
         chk("mt_write", {32'd0, (op == 3'd4) ? hi_v[i] : lo_v[i]}, {32'd0, a});
      end
   endtask

   initial begin
      reset = 1'b0; op_valid_v = 2'b00; op_code = 3'd7;
      operand_a = 32'h0; operand_b = 32'h0; flush = 1'b0;
      repeat (2) @(posedge clock); #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_hi", {32'd0, hi_v[i]}, 64'd0);
         chk("reset_lo", {32'd0, lo_v[i]}, 64'd0);
      end
      chk("reset_stall", {62'd0, stall_v}, 64'd0);
      chk("reset_done", {62'd0, done_v | dbz_v}, 64'd0);
      reset = 1'b1;
      @(posedge clock); #1;

      mt_op(3'd4, 32'h1234_5678);
      mt_op(3'd5, 32'h0BAD_F00D);

      // Reset while a MULTU is iterating
      op_valid_v = 2'b01; op_code = 3'd1; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      op_valid_v = 2'b00;
      repeat (5) @(posedge clock); #1;
      chk("busy_before_reset", {63'd0, stall_v[0]}, 64'd1);
      reset = 1'b0; #1;
      chk("midop_reset_hi", {32'd0, hi_v[0]}, 64'd0);
      chk("midop_reset_lo", {32'd0, lo_v[0]}, 64'd0);
      chk("midop_reset_stall", {63'd0, stall_v[0]}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (40) @(posedge clock); #1;
      chk("idle_after_reset", {62'd0, stall_v}, 64'd0);

      do_op(2'b11, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 10);
      do_op(2'b11, 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 10);
      do_op(2'b11, 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 34);
      do_op(2'b11, 3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 34, 34);
      do_op(2'b11, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 34);
      mt_op(3'd4, 32'h1234_5678);
      do_op(2'b11, 3'd2, 32'h0000_0005, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000, 1'b1, 2, 2);

      // MULT aborted by flush on its tenth CALC cycle, then MULTU accepted right after
      op_valid_v = 2'b01; op_code = 3'd0; operand_a = 32'h0000_0007; operand_b = 32'h0000_0009;
      @(posedge clock); #1;
      op_valid_v = 2'b00;
      repeat (9) @(posedge clock); #1;
      chk("calc_before_flush", {63'd0, stall_v[0]}, 64'd1);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      chk("flush_no_done", {63'd0, done_v[0]}, 64'd0);
      chk("flush_idle", {63'd0, stall_v[0]}, 64'd0);
      chk("flush_hi_kept", {32'd0, hi_v[0]}, {32'd0, 32'h1234_5678});
      chk("flush_lo_kept", {32'd0, lo_v[0]}, {32'd0, 32'h8000_0000});
      do_op(2'b01, 3'd1, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 34, 0);

      repeat (3) @(posedge clock); #1;
      chk("scoreboard_drained0", 64'(exp_q[0].size()), 64'd0);
      chk("scoreboard_drained1", 64'(exp_q[1].size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
